imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_word_packer.sv | 38 +++
 rtl/imem_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: state encoding,
// word geometry and header width.
package imem_loader_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int BYTES_PER_WORD = DEFAULT_DATA_W / 8;
   localparam int HEADER_W       = 8;

   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_RECV  = 3'd1;
   localparam logic [STATE_W-1:0] ST_WRITE = 3'd2;
   localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;
   localparam logic [STATE_W-1:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-bank write port of the boot loader.
// master = stream source / bank side, slave = the loader itself.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) ();

   logic                in_valid;
   logic [HEADER_W-1:0] in_data;
   logic                in_ready;
   logic                mem_write;
   logic [ADDR_W-1:0]   mem_address;
   logic [DATA_W-1:0]   mem_writedata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_write, mem_address, mem_writedata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_write, mem_address, mem_writedata
   );

endinterface

// File: rtl/imem_word_packer.sv
// Assembles accepted bytes MSB-first into a word; word_valid flags the byte
// that completes it, with the full word presented combinationally on word.
module imem_word_packer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [7:0]        byte_in,
   output logic              word_valid,
   output logic [DATA_W-1:0] word
);

   localparam int BPW   = DATA_W / 8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CNT_W-1:0]  byte_cnt;
   logic [DATA_W-9:0] shift_q;

   assign word_valid = byte_en && (byte_cnt == CNT_W'(BPW - 1));
   assign word       = {shift_q, byte_in};

   // Only the low bytes need storing; the newest byte arrives on byte_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         shift_q  <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
         shift_q  <= '0;
      end else if (byte_en) begin
         shift_q  <= word[DATA_W-9:0];
         byte_cnt <= word_valid ? '0 : byte_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the instruction bank; holds the core until loaded.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus,
   input  logic         reload,
   output logic         cpu_hold,
   output logic         done,
   output logic         error
);

   logic [STATE_W-1:0] state;
   logic [ADDR_W-1:0]  word_idx;
   logic [ADDR_W:0]    words_written;
   logic [ADDR_W:0]    target;
   logic               mem_write_q;
   logic [ADDR_W-1:0]  mem_address_q;
   logic [DATA_W-1:0]  mem_writedata_q;

   logic              accept;
   logic              data_byte;
   logic              reload_ok;
   logic              word_valid;
   logic [DATA_W-1:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] chk_xor;

   assign bus.in_ready = !rst && (state == ST_IDLE || state == ST_RECV || state == ST_CHECK);
   assign reload_ok    = reload && (state == ST_DONE || state == ST_ERR);
   assign error        = (state == ST_ERR);
`else
   assign bus.in_ready = !rst && (state == ST_IDLE || state == ST_RECV);
   assign reload_ok    = reload && (state == ST_DONE);
   assign error        = 1'b0;
`endif

   assign accept            = bus.in_valid && bus.in_ready;
   assign data_byte         = accept && (state == ST_RECV);
   assign cpu_hold          = (state != ST_DONE);
   assign done              = (state == ST_DONE);
   assign bus.mem_write     = mem_write_q;
   assign bus.mem_address   = mem_address_q;
   assign bus.mem_writedata = mem_writedata_q;

   imem_word_packer #(.DATA_W(DATA_W)) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (reload_ok),
      .byte_en    (data_byte),
      .byte_in    (bus.in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // Termination is by word count against the header (0 means a full bank),
   // so the address may wrap after the final write without side effects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         word_idx        <= '0;
         words_written   <= '0;
         target          <= '0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
      end else begin
         mem_write_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  target <= (bus.in_data == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                : (ADDR_W+1)'(bus.in_data);
                  state  <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (word_valid) begin
                  mem_write_q     <= 1'b1;
                  mem_address_q   <= word_idx;
                  mem_writedata_q <= word;
                  state           <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               word_idx      <= word_idx + ADDR_W'(1);
               words_written <= words_written + (ADDR_W+1)'(1);
               if ((words_written + (ADDR_W+1)'(1)) == target) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= ST_CHECK;
`else
                  state <= ST_DONE;
`endif
               end else begin
                  state <= ST_RECV;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (accept) state <= (bus.in_data == chk_xor) ? ST_DONE : ST_ERR;
            end
            ST_ERR: begin
               if (reload_ok) begin
                  state         <= ST_IDLE;
                  word_idx      <= '0;
                  words_written <= '0;
               end
            end
`endif
            ST_DONE: begin
               if (reload_ok) begin
                  state         <= ST_IDLE;
                  word_idx      <= '0;
                  words_written <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running XOR of data bytes only; header and checksum byte are excluded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            chk_xor <= '0;
      else if (reload_ok) chk_xor <= '0;
      else if (data_byte) chk_xor <= chk_xor ^ bus.in_data;
   end
`endif

endmodule
